inv_sub_bytes_serial: RTL and testbench

- Low-area inverse SubBytes engine for the AES-128 decryption datapath.
- Accepts a 128-bit state and substitutes each byte through one shared combinational inverse S-box, BYTES_PER_CYCLE bytes per clock.
- Returns the 128-bit result over a valid/ready handshake.
- Counterpart of the forward sbox used by the encryption path; sits between the InvShiftRows and AddRoundKey stages of the low-area decryptor.

---
 rtl/inv_sub_bytes_serial.sv | 165 ++++++++++++++++
 tb/tb_inv_sub_bytes_serial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_serial.sv
`timescale 1ns/1ps
// inv_sub_bytes_serial: low-area AES inverse SubBytes engine.
// Accepts a 128-bit state, substitutes BYTES_PER_CYCLE bytes per clock through
// shared inverse S-boxes, then presents the result over a valid/ready handshake.
// Optional macro INV_CHECK_EN adds forward S-box self-check with a sticky err port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake; in_ready high only when idle
//   in_state[127:0]       byte 0 = [127:120], byte 15 = [7:0]
//   out_valid/out_ready   output handshake
//   out_state[127:0]      inverse-substituted state, same byte order
//   busy                  high while substituting or holding a result
//   err                   (INV_CHECK_EN only) forward re-check mismatch, sticky
module inv_sub_bytes_serial #(
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
`ifdef INV_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int unsigned N        = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [127:0]       work_q, work_nxt;
    logic               in_ready_nxt, out_valid_nxt, busy_nxt;
    int unsigned        idx;
    logic [7:0]         orig_b;
`ifdef INV_CHECK_EN
    logic               err_nxt;
`endif

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = x;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by field inversion
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

`ifdef INV_CHECK_EN
    // Forward S-box used to re-derive the original byte
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef INV_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            work_q    <= work_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
`ifdef INV_CHECK_EN
            err       <= err_nxt;
`endif
        end
    end

    // Next-state, chunk substitution and registered-output decode
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        work_nxt  = work_q;
        idx       = 0;
        orig_b    = 8'h00;
`ifdef INV_CHECK_EN
        err_nxt   = err;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_nxt  = in_state;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
`ifdef INV_CHECK_EN
                    err_nxt   = 1'b0;
`endif
                end
            end
            RUN: begin
                for (int b = 0; b < int'(BYTES_PER_CYCLE); b++) begin
                    idx    = 32'(cnt_q) * BYTES_PER_CYCLE + 32'(b);
                    orig_b = work_q[8*(15 - idx) +: 8];
                    work_nxt[8*(15 - idx) +: 8] = inv_sbox(orig_b);
`ifdef INV_CHECK_EN
                    if (fwd_sbox(work_nxt[8*(15 - idx) +: 8]) != orig_b) err_nxt = 1'b1;
`endif
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt != IDLE);
    end

    assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
`timescale 1ns/1ps
module tb_inv_sub_bytes_serial;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready;
    logic [127:0] in_state;
    logic         ir1, ov1, bz1, ir4, ov4, bz4, ir16, ov16, bz16;
    logic [127:0] os1, os4, os16;
`ifdef INV_CHECK_EN
    logic         e1, e4, e16;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    inv_sub_bytes_serial #(.BYTES_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_state(in_state),
        .out_valid(ov1), .out_ready(out_ready), .out_state(os1), .busy(bz1)
`ifdef INV_CHECK_EN
        , .err(e1)
`endif
    );
    inv_sub_bytes_serial #(.BYTES_PER_CYCLE(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_state(in_state),
        .out_valid(ov4), .out_ready(out_ready), .out_state(os4), .busy(bz4)
`ifdef INV_CHECK_EN
        , .err(e4)
`endif
    );
    inv_sub_bytes_serial #(.BYTES_PER_CYCLE(16)) u_b16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_state(in_state),
        .out_valid(ov16), .out_ready(out_ready), .out_state(os16), .busy(bz16)
`ifdef INV_CHECK_EN
        , .err(e16)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: build forward S-box from field inverse by search, then invert the table
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_ref();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h63;
            for (int k = 0; k < 5; k++) s = s ^ 8'((({inv, inv} << k) >> 8));
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_state(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = inv_tab[st[8*(15-i) +: 8]];
        return r;
    endfunction

    // Send one state through the B=1 engine and check latency and result
    task automatic send_check(input string name, input logic [127:0] st,
                              input logic [127:0] exp, input int stall);
        int t0, w;
        w = 0;
        while (!ir1 && w < 50) begin tick(); w++; end
        chk({name, " ready"}, 128'(ir1), 128'd1);
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        t0 = cyc;
        w = 0;
        while (!ov1 && w < 40) begin tick(); w++; end
        chk({name, " latency"}, 128'(cyc - t0), 128'd16);
        chk({name, " data"}, os1, exp);
`ifdef INV_CHECK_EN
        chk({name, " err"}, 128'(e1), 128'd0);
`endif
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " release"}, 128'(ov1), 128'd0);
    endtask

    typedef struct {
        string        name;
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] st, ex, hold;
        int lat [3];
        int tv [3];
        int t0, idx, nres;
        logic acc;
        logic [127:0] st3 [3];
        logic [127:0] ex3 [3];

        vecs[0] = '{"fips_row0", 128'h637c777bf26b6fc53001672bfed7ab76,
                    128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{"corners",   128'h006316ed006316ed006316ed006316ed,
                    128'h5200ff535200ff535200ff535200ff53};
        vecs[2] = '{"all_63",    {16{8'h63}}, 128'h0};

        build_ref();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        #23;
        chk("reset in_ready",  128'(ir1), 128'd1);
        chk("reset out_valid", 128'(ov1), 128'd0);
        chk("reset busy",      128'(bz1), 128'd0);
        chk("reset out_state", os1, 128'h0);
        rst_n = 1'b1;
        tick();

        // Corners on all three widths at once
        in_valid = 1'b1;
        in_state = vecs[1].st;
        tick();
        in_valid = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 3; i++) lat[i] = -1;
        for (int c = 0; c < 20; c++) begin
            if (ov1  && lat[0] < 0) lat[0] = cyc - t0;
            if (ov4  && lat[1] < 0) lat[1] = cyc - t0;
            if (ov16 && lat[2] < 0) lat[2] = cyc - t0;
            tick();
        end
        chk("b1 latency",  128'(lat[0]), 128'd16);
        chk("b4 latency",  128'(lat[1]), 128'd4);
        chk("b16 latency", 128'(lat[2]), 128'd1);
        chk("b1 corners",  os1,  vecs[1].exp);
        chk("b4 corners",  os4,  vecs[1].exp);
        chk("b16 corners", os16, vecs[1].exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Table vectors
        for (int i = 0; i < 3; i++) send_check(vecs[i].name, vecs[i].st, vecs[i].exp, i);

        // Exhaustive byte coverage against reference
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) st[8*(15-j) +: 8] = 8'(16*k + j);
            send_check($sformatf("exh%0d", k), st, ref_state(st), 0);
        end

        // Random states with random output stall
        for (int k = 0; k < 12; k++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            send_check($sformatf("rand%0d", k), st, ref_state(st), int'($urandom_range(0, 3)));
        end

        // Backpressure: hold result 20 cycles while in_valid pulses
        st = {$urandom, $urandom, $urandom, $urandom};
        ex = ref_state(st);
        in_valid = 1'b1; in_state = st;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 40 && !ov1; w++) tick();
        hold = os1;
        chk("bp data", hold, ex);
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (os1 !== hold || !ov1 || ir1) begin
                chk($sformatf("bp hold%0d", c), {os1[127:2], ov1, ir1}, {hold[127:2], 2'b10});
            end else begin
                n_cmp++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp out_valid drop", 128'(ov1), 128'd0);
        chk("bp in_ready back",  128'(ir1), 128'd1);

        // Reset mid-RUN at chunk 7
        in_valid = 1'b1; in_state = vecs[0].st;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        chk("midrun busy", 128'(bz1), 128'd1);
        rst_n = 1'b0;
        #2;
        chk("midrun async out_valid", 128'(ov1), 128'd0);
        chk("midrun async in_ready",  128'(ir1), 128'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post reset out_valid", 128'(ov1), 128'd0);
        chk("post reset in_ready",  128'(ir1), 128'd1);
        send_check("after_reset_63", {16{8'h63}}, 128'h0, 0);

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 3; i++) begin
            st3[i] = {$urandom, $urandom, $urandom, $urandom};
            ex3[i] = ref_state(st3[i]);
        end
        idx = 0; nres = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && nres < 3; c++) begin
            in_valid = (idx < 3);
            in_state = (idx < 3) ? st3[idx] : '0;
            acc = ir1 && in_valid;
            tick();
            if (acc) idx++;
            if (ov1) begin
                chk($sformatf("b2b data%0d", nres), os1, ex3[nres]);
                tv[nres] = cyc;
                nres++;
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("b2b count", 128'(nres), 128'd3);
        if (nres == 3) begin
            chk("b2b spacing01", 128'(tv[1] - tv[0]), 128'd18);
            chk("b2b spacing12", 128'(tv[2] - tv[1]), 128'd18);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
